lpe_column_result_collector: RTL and testbench
==============================================

# lpe_column_result_collector

Receive-side terminus of one processing-array column. Consumes the AXI-Stream leaving the down port of the bottom linear processing element (operand pass-through beats interleaved with result beats, results arriving in PE order 0..PE_NUMBER_J-1), discards non-result traffic, and re-emits each result as an indexed AXI-Stream beat with tlast closing every column tile. Sits between the column's bottom PE and the output interconnect; flags tagging and framing errors.

## Interface
- PE_NUMBER_J, 4, results per tile (PEs in the column); ≥2
- DATA_WIDTH, 16, result width
- USER_WIDTH, 8, input tuser width
- OP1_USER_MASK, 1<<(USER_WIDTH-2), tuser bit marking an operand-1 beat
- RSLT_USER_MASK, 1<<(USER_WIDTH-1), tuser bit marking a result beat
- OUTPUT_ID, 1, constant driven on m_axis_tid
- OUTPUT_DEST, 1, constant driven on m_axis_tdest
- IDX_WIDTH, max(1,$clog2(PE_NUMBER_J)), index width
- clk  in  1  single clock, all logic rising-edge
- rstn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  column payload
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  set on the last result of a tile
- s_axis_tuser  in  USER_WIDTH  beat type flags
- m_axis_tdata  out  DATA_WIDTH  result
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  high on index PE_NUMBER_J-1
- m_axis_tuser  out  IDX_WIDTH  PE index of the result
- m_axis_tid  out  8  OUTPUT_ID
- m_axis_tdest  out  8  OUTPUT_DEST
- tile_done  out  1  one-cycle pulse when a tile's last result is accepted at input
- err_user_flag  out  1  one-cycle pulse: beat with both or neither mask bit set
- err_framing  out  1  one-cycle pulse: tlast/count mismatch

## Operation
- Beat classes (on s handshake): RES = RSLT bit only; OP = OP1 bit only; BAD = both or neither.
- OP: consumed and dropped, no other effect.
- BAD: consumed and dropped; err_user_flag pulses next cycle; count unchanged.
- RES: loaded into output register with m_axis_tuser = idx, m_axis_tlast = (idx == PE_NUMBER_J-1); idx increments, wraps to 0 after PE_NUMBER_J-1.
- FSM states: IDLE (idx=0), COLLECT (0<idx<PE_NUMBER_J), ERR.
  - IDLE --RES--> COLLECT (or stays IDLE if PE_NUMBER_J reached on wrap).
  - COLLECT --RES with idx=PE_NUMBER_J-1 and s_axis_tlast--> IDLE, tile_done pulse.
  - Framing error: RES with s_axis_tlast and idx≠PE_NUMBER_J-1 (short tile), or RES at idx=PE_NUMBER_J-1 without s_axis_tlast (long tile) -> ERR. Offending result is still emitted with its idx and m_axis_tlast forced high to close the output frame.
  - ERR: one cycle, s_axis_tready=0, err_framing pulses, idx cleared -> IDLE.
- tlast on OP/BAD beats ignored.

## Timing
- Reset (rstn low, asynchronous): state IDLE, idx 0, m_axis_tvalid 0, m_axis_tdata/tuser/tlast 0, tile_done 0, errors 0, s_axis_tready 0. tid/tdest constant.
- s_axis_tready = (state≠ERR) && (!m_axis_tvalid || m_axis_tready), combinational; no dependency on s_axis_tvalid.
- Latency: RES accepted at edge N appears on m_axis at edge N (valid from N to downstream handshake); one cycle input-to-output register.
- Throughput: one beat per cycle when m_axis_tready held high.
- Output register held stable while m_axis_tvalid && !m_axis_tready; OP/BAD beats also stall in that condition (uniform tready).
- Simultaneous output handshake and new RES: register reloads same edge, no bubble.
- Error and tile_done pulses asserted the cycle after the causing input handshake, registered.
- Reset mid-tile: any held output beat lost; next tile starts at idx 0.

## Test plan
- N=4, m_tready=1: RES 0xA0..0xA3 (tlast on 4th) interleaved with 3 OP beats -> out 0xA0..0xA3, tuser 0,1,2,3, tlast only on 0xA3, tile_done once, no errors.
- Backpressure: m_tready toggled 1/0 every cycle over 2 tiles -> 8 results in order, no loss/duplication, tdata stable while stalled.
- Short tile: RES 0x10,0x11 with tlast on 0x11 -> out tuser 0,1, tlast on 0x11, err_framing pulse, one cycle tready=0; next tile starts at tuser 0.
- Long tile: 4 RES, none with tlast -> 4th emitted with tlast, err_framing; 5th RES emitted with tuser 0.
- tuser with both mask bits, then tuser=0 -> two err_user_flag pulses, nothing emitted, idx unchanged.
- rstn low mid-tile after 2 results with output stalled -> m_tvalid 0 immediately; after release a full tile emits tuser 0..3.

Source files
------------

// File: rtl/lpe_column_result_collector.sv
// Column result collector: drops operand pass-through beats from the bottom PE,
// re-emits each result with its PE index, and closes every output tile with tlast.
module lpe_column_result_collector #(
  parameter int PE_NUMBER_J = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int USER_WIDTH  = 8,
  parameter logic [USER_WIDTH-1:0] OP1_USER_MASK  = USER_WIDTH'(1 << (USER_WIDTH-2)),
  parameter logic [USER_WIDTH-1:0] RSLT_USER_MASK = USER_WIDTH'(1 << (USER_WIDTH-1)),
  parameter int OUTPUT_ID   = 1,
  parameter int OUTPUT_DEST = 1,
  parameter int IDX_WIDTH   = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [IDX_WIDTH-1:0]  m_axis_tuser,
  output logic [7:0]            m_axis_tid,
  output logic [7:0]            m_axis_tdest,
  output logic                  tile_done,
  output logic                  err_user_flag,
  output logic                  err_framing
);

  typedef enum logic [1:0] {IDLE, COLLECT, ERR} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PE_NUMBER_J - 1);

  state_t                r_state;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_ready_en;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [IDX_WIDTH-1:0]  r_m_user;
  logic                  r_tile_done;
  logic                  r_err_user;
  logic                  r_err_framing;

  logic w_op1;
  logic w_rslt;
  logic w_is_res;
  logic w_is_bad;
  logic w_s_ready;
  logic w_in_hs;
  logic w_res_hs;
  logic w_at_last;
  logic w_frame_err;

  assign w_op1       = |(s_axis_tuser & OP1_USER_MASK);
  assign w_rslt      = |(s_axis_tuser & RSLT_USER_MASK);
  assign w_is_res    = w_rslt && !w_op1;
  assign w_is_bad    = (w_rslt == w_op1);
  // r_ready_en keeps tready low while reset is held and for the first edge after release
  assign w_s_ready   = r_ready_en && (r_state != ERR) && (!r_m_valid || m_axis_tready);
  assign w_in_hs     = s_axis_tvalid && w_s_ready;
  assign w_res_hs    = w_in_hs && w_is_res;
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_frame_err = w_res_hs && (s_axis_tlast != w_at_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_ready_en    <= 1'b0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_m_user      <= '0;
      r_tile_done   <= 1'b0;
      r_err_user    <= 1'b0;
      r_err_framing <= 1'b0;
    end else begin
      r_ready_en    <= 1'b1;
      r_tile_done   <= w_res_hs && w_at_last && s_axis_tlast;
      r_err_user    <= w_in_hs && w_is_bad;
      r_err_framing <= w_frame_err;

      // A framing error still emits the offending result, with tlast forced to close the frame
      if (w_res_hs) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_axis_tdata;
        r_m_user  <= r_idx;
        r_m_last  <= w_at_last || s_axis_tlast;
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        ERR: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
        default: begin
          if (w_res_hs) begin
            if (w_frame_err) begin
              r_state <= ERR;
              r_idx   <= '0;
            end else if (w_at_last) begin
              r_state <= IDLE;
              r_idx   <= '0;
            end else begin
              r_state <= COLLECT;
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tuser  = r_m_user;
  assign m_axis_tid    = 8'(OUTPUT_ID);
  assign m_axis_tdest  = 8'(OUTPUT_DEST);
  assign tile_done     = r_tile_done;
  assign err_user_flag = r_err_user;
  assign err_framing   = r_err_framing;

endmodule

// File: tb/tb_lpe_column_result_collector.sv
// Scoreboard bench for lpe_column_result_collector: a negedge monitor models index,
// tlast and pulse timing; scenario tasks drive beats and check per-scenario totals.
module tb_lpe_column_result_collector;

  localparam int N = 4;
  localparam logic [7:0] U_RES  = 8'h80;
  localparam logic [7:0] U_OP   = 8'h40;
  localparam logic [7:0] U_BOTH = 8'hC0;
  localparam logic [7:0] U_NONE = 8'h00;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tuser = '0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tuser;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic        tile_done;
  logic        err_user_flag;
  logic        err_framing;

  beat_t sbq[$];
  beat_t cur_beat, prev_beat, exp_beat;
  int    tests = 0;
  int    fails = 0;
  int    act_out = 0, act_td = 0, act_ue = 0, act_fe = 0;
  int    e_idx = 0;
  bit    pend_td = 0, pend_ue = 0, pend_fe = 0;
  bit    prev_stall = 0;
  bit    bp_mode = 0;

  lpe_column_result_collector #(
    .PE_NUMBER_J(N),
    .DATA_WIDTH(16),
    .USER_WIDTH(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest),
    .tile_done(tile_done),
    .err_user_flag(err_user_flag),
    .err_framing(err_framing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bp_mode) m_axis_tready = ~m_axis_tready;
  end

  // Inputs only change just after a rising edge, so what the monitor sees at the
  // falling edge is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    cur_beat = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    if (!rstn) begin
      sbq.delete();
      e_idx = 0;
      pend_td = 0; pend_ue = 0; pend_fe = 0;
      prev_stall = 0;
    end else begin
      tests++;
      if ({tile_done, err_user_flag, err_framing} !== {pend_td, pend_ue, pend_fe}) begin
        fails++;
        $display("[TB] FAIL pulses: got td/ue/fe=%b%b%b exp %b%b%b at %0t",
                 tile_done, err_user_flag, err_framing, pend_td, pend_ue, pend_fe, $time);
      end
      if (tile_done) act_td++;
      if (err_user_flag) act_ue++;
      if (err_framing) act_fe++;
      if (pend_fe) begin
        tests++;
        if (s_axis_tready !== 1'b0) begin
          fails++;
          $display("[TB] FAIL err_tready: got %b exp 0 at %0t", s_axis_tready, $time);
        end
      end
      if (prev_stall && m_axis_tvalid) begin
        tests++;
        if (cur_beat !== prev_beat) begin
          fails++;
          $display("[TB] FAIL stall_hold: got %h exp %h at %0t", cur_beat, prev_beat, $time);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur_beat;
      if (m_axis_tvalid && m_axis_tready) begin
        act_out++;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_beat: got %h exp none at %0t", cur_beat, $time);
        end else begin
          exp_beat = sbq.pop_front();
          if (cur_beat !== exp_beat) begin
            fails++;
            $display("[TB] FAIL beat: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                     cur_beat.d, cur_beat.u, cur_beat.l, exp_beat.d, exp_beat.u, exp_beat.l);
          end
        end
      end
      pend_td = 0; pend_ue = 0; pend_fe = 0;
      if (s_axis_tvalid && s_axis_tready) begin
        if (s_axis_tuser[7] == s_axis_tuser[6]) pend_ue = 1;
        if (s_axis_tuser[7] && !s_axis_tuser[6]) begin
          sbq.push_back({s_axis_tdata, 2'(e_idx), (e_idx == N-1) || s_axis_tlast});
          if (s_axis_tlast != (e_idx == N-1)) begin
            pend_fe = 1;
            e_idx = 0;
          end else if (e_idx == N-1) begin
            pend_td = 1;
            e_idx = 0;
          end else begin
            e_idx++;
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [7:0] u, input logic l);
    bit hs;
    int n;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      #1;
      hs = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 100);
    tests++;
    if (!hs) begin
      fails++;
      $display("[TB] FAIL send_timeout: got no tready exp handshake for data %h", d);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || m_axis_tvalid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, s_axis_tready,
         tile_done, err_user_flag, err_framing} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h u=%0d l=%b rdy=%b pulses=%b%b%b exp all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, s_axis_tready,
               tile_done, err_user_flag, err_framing);
    end
    tests++;
    if ({m_axis_tid, m_axis_tdest} !== {8'd1, 8'd1}) begin
      fails++;
      $display("[TB] FAIL tid_tdest: got %h/%h exp 01/01", m_axis_tid, m_axis_tdest);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_held: got v=%b rdy=%b exp 0 0", m_axis_tvalid, s_axis_tready);
    end
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (s_axis_tready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_reset: got %b exp 1", s_axis_tready);
    end
  endtask

  task automatic test_basic_tile();
    int o0 = act_out, t0 = act_td, u0 = act_ue, f0 = act_fe;
    m_axis_tready = 1'b1;
    send(16'h00F0, U_OP, 1'b0);
    send(16'h00A0, U_RES, 1'b0);
    send(16'h00F1, U_OP, 1'b1);
    send(16'h00A1, U_RES, 1'b0);
    send(16'h00F2, U_OP, 1'b0);
    send(16'h00A2, U_RES, 1'b0);
    send(16'h00A3, U_RES, 1'b1);
    wait_drain();
    @(posedge clk); #1;
    tests++;
    if ({act_out - o0, act_td - t0, act_ue - u0, act_fe - f0} !== {32'd4, 32'd1, 32'd0, 32'd0}) begin
      fails++;
      $display("[TB] FAIL basic_counts: got out=%0d td=%0d ue=%0d fe=%0d exp 4 1 0 0",
               act_out - o0, act_td - t0, act_ue - u0, act_fe - f0);
    end
  endtask

  task automatic test_backpressure();
    int o0 = act_out, t0 = act_td;
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(16'h00B0 + 16'(i), U_RES, (i % 4) == 3);
    wait_drain();
    bp_mode = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({act_out - o0, act_td - t0, sbq.size()} !== {32'd8, 32'd2, 32'd0}) begin
      fails++;
      $display("[TB] FAIL bp_counts: got out=%0d td=%0d left=%0d exp 8 2 0",
               act_out - o0, act_td - t0, sbq.size());
    end
  endtask

  task automatic test_short_tile();
    int o0 = act_out, t0 = act_td, f0 = act_fe;
    send(16'h0010, U_RES, 1'b0);
    send(16'h0011, U_RES, 1'b1);
    for (int i = 0; i < 4; i++) send(16'h0020 + 16'(i), U_RES, i == 3);
    wait_drain();
    @(posedge clk); #1;
    tests++;
    if ({act_out - o0, act_td - t0, act_fe - f0} !== {32'd6, 32'd1, 32'd1}) begin
      fails++;
      $display("[TB] FAIL short_counts: got out=%0d td=%0d fe=%0d exp 6 1 1",
               act_out - o0, act_td - t0, act_fe - f0);
    end
  endtask

  task automatic test_long_tile();
    int o0 = act_out, t0 = act_td, f0 = act_fe;
    for (int i = 0; i < 4; i++) send(16'h0030 + 16'(i), U_RES, 1'b0);
    for (int i = 4; i < 8; i++) send(16'h0030 + 16'(i), U_RES, i == 7);
    wait_drain();
    @(posedge clk); #1;
    tests++;
    if ({act_out - o0, act_td - t0, act_fe - f0} !== {32'd8, 32'd1, 32'd1}) begin
      fails++;
      $display("[TB] FAIL long_counts: got out=%0d td=%0d fe=%0d exp 8 1 1",
               act_out - o0, act_td - t0, act_fe - f0);
    end
  endtask

  task automatic test_user_err();
    int o0 = act_out, t0 = act_td, u0 = act_ue, f0 = act_fe;
    send(16'h0040, U_RES, 1'b0);
    send(16'h0EEE, U_BOTH, 1'b1);
    send(16'h0DDD, U_NONE, 1'b0);
    send(16'h0041, U_RES, 1'b0);
    send(16'h0042, U_RES, 1'b0);
    send(16'h0043, U_RES, 1'b1);
    wait_drain();
    @(posedge clk); #1;
    tests++;
    if ({act_out - o0, act_td - t0, act_ue - u0, act_fe - f0} !== {32'd4, 32'd1, 32'd2, 32'd0}) begin
      fails++;
      $display("[TB] FAIL user_err_counts: got out=%0d td=%0d ue=%0d fe=%0d exp 4 1 2 0",
               act_out - o0, act_td - t0, act_ue - u0, act_fe - f0);
    end
  endtask

  task automatic test_reset_mid_tile();
    int o0, t0;
    m_axis_tready = 1'b1;
    send(16'h0050, U_RES, 1'b0);
    send(16'h0051, U_RES, 1'b0);
    m_axis_tready = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    tests++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_mid: got v=%b rdy=%b exp 0 0", m_axis_tvalid, s_axis_tready);
    end
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    o0 = act_out; t0 = act_td;
    for (int i = 0; i < 4; i++) send(16'h0060 + 16'(i), U_RES, i == 3);
    wait_drain();
    @(posedge clk); #1;
    tests++;
    if ({act_out - o0, act_td - t0, sbq.size()} !== {32'd4, 32'd1, 32'd0}) begin
      fails++;
      $display("[TB] FAIL post_reset_counts: got out=%0d td=%0d left=%0d exp 4 1 0",
               act_out - o0, act_td - t0, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_tile();
    test_backpressure();
    test_short_tile();
    test_long_tile();
    test_user_err();
    test_reset_mid_tile();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
